// File: rtl/npu_fifo_pkg.sv
// Shared definitions for the NPU stream FIFO family: default queue
// geometries, the level-flag bundle and an elaboration-time log2 helper.
package npu_fifo_pkg;

   // Default word widths and address width of the NPU queues
   localparam int NPU_IN_W    = 32;
   localparam int NPU_CFG_W   = 26;
   localparam int NPU_OUT_W   = 32;
   localparam int NPU_FIFO_AW = 4;

   // Level flags decoded from the occupancy count
   typedef struct packed {
      logic full;
      logic afull;
      logic empty;
      logic aempty;
   } fifo_level_t;

   // Ceiling log2, usable in parameter expressions (clog2(1) == 0)
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage : npu_fifo_pkg

// File: rtl/npu_fifo_mem.sv
// DATA_W x DEPTH register array with one write port and one read port.
// FWFT=0: the read word is registered on rd_en (latency 1, reset to 0).
// FWFT=1: the read word is a combinational view of mem[rd_addr].
// The owning FIFO never reads a word in its own write cycle, so no
// read-during-write forwarding is needed.
module npu_fifo_mem
   import npu_fifo_pkg::*;
#(
   parameter int DATA_W = NPU_IN_W,
   parameter int DEPTH  = 2 ** NPU_FIFO_AW,
   parameter bit FWFT   = 1'b0,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; storage is deliberately not reset
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   generate
      if (FWFT) begin : g_comb_read
         // Head word is always visible; control inputs only matter in registered mode
         logic unused_rd_ctrl;
         assign unused_rd_ctrl = RST ^ rd_en;
         assign rd_data = mem[rd_addr];
      end else begin : g_reg_read
         logic [DATA_W-1:0] rd_q;
         // Registered read: capture the addressed word when a pop is accepted
         always_ff @(posedge CLK) begin
            if (RST) begin
               rd_q <= '0;
            end else if (rd_en) begin
               rd_q <= mem[rd_addr];
            end
         end
         assign rd_data = rd_q;
      end
   endgenerate

endmodule : npu_fifo_mem

// File: rtl/npu_stream_fifo.sv
// Parametrised synchronous FIFO used for all processor<->NPU queues.
// Handshake: a write is accepted when wr_en & ~full, a read/pop when
// rd_en & ~empty, both judged on the registered count of the current
// cycle; flush suppresses both. Standard mode presents the popped word
// with a one-cycle rd_valid pulse the cycle after acceptance; FWFT mode
// presents the head word whenever rd_valid (= ~empty) is high and rd_en
// acknowledges it. Rejected requests set sticky overflow/underflow flags.
module npu_stream_fifo
   import npu_fifo_pkg::*;
#(
   parameter int DATA_W    = NPU_IN_W,
   parameter int ADDR_W    = NPU_FIFO_AW,
   parameter bit FWFT      = 1'b0,
   parameter int AFULL_TH  = (2 ** ADDR_W) - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              flush,
   input  logic              err_clr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic              afull,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic              aempty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Thresholds sized to the count register so the decodes compare like widths
   localparam logic [ADDR_W:0] FULL_CNT   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AFULL_CNT  = AFULL_TH[ADDR_W:0];
   localparam logic [ADDR_W:0] AEMPTY_CNT = AEMPTY_TH[ADDR_W:0];

   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic              overflow_q;
   logic              underflow_q;
   logic              wr_acc;
   logic              rd_acc;
   logic              wr_reject;
   logic              rd_reject;
   logic [DATA_W-1:0] mem_rd_data;
   fifo_level_t       level;

   // Level flags come only from the registered count, never from pointer compare
   always_comb begin
      level        = '0;
      level.full   = (count_q == FULL_CNT);
      level.afull  = (count_q >= AFULL_CNT);
      level.empty  = (count_q == '0);
      level.aempty = (count_q <= AEMPTY_CNT);
   end

   // Accept/reject decisions; flush swallows both requests without error
   always_comb begin
      wr_acc    = 1'b0;
      rd_acc    = 1'b0;
      wr_reject = 1'b0;
      rd_reject = 1'b0;
      if (!flush) begin
         wr_acc    = wr_en & ~level.full;
         rd_acc    = rd_en & ~level.empty;
         wr_reject = wr_en & level.full;
         rd_reject = rd_en & level.empty;
      end
   end

   // Pointers advance on accepted operations; wrap is natural at 2**(ADDR_W+1)
   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy register: +1 write only, -1 read only, hold otherwise
   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         count_q <= '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky error flags: a new event beats err_clr; flush leaves them alone
   always_ff @(posedge CLK) begin
      if (RST) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_reject) begin
            overflow_q <= 1'b1;
         end else if (err_clr) begin
            overflow_q <= 1'b0;
         end
         if (rd_reject) begin
            underflow_q <= 1'b1;
         end else if (err_clr) begin
            underflow_q <= 1'b0;
         end
      end
   end

   npu_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .FWFT   (FWFT)
   ) u_mem (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (wr_data),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (mem_rd_data)
   );

   generate
      if (FWFT) begin : g_fwft
         // Head word is valid whenever data is queued; masked to 0 while empty
         assign rd_valid = ~level.empty;
         assign rd_data  = level.empty ? '0 : mem_rd_data;
      end else begin : g_std
         logic rd_valid_q;
         // One-cycle valid pulse per accepted read; reset/flush kill a pending pulse
         always_ff @(posedge CLK) begin
            if (RST || flush) begin
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
            end
         end
         assign rd_valid = rd_valid_q;
         assign rd_data  = mem_rd_data;
      end
   endgenerate

   assign full      = level.full;
   assign afull     = level.afull;
   assign empty     = level.empty;
   assign aempty    = level.aempty;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule : npu_stream_fifo

// File: tb/tb_npu_stream_fifo.sv
// Bench for npu_stream_fifo: three instances (default standard mode,
// 26-bit FWFT, 4-deep standard) against a queue-based reference model.
module tb_npu_stream_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance 0: defaults ----------------
  logic        flush0 = 0, err_clr0 = 0, wr_en0 = 0, rd_en0 = 0;
  logic [31:0] wr_data0 = '0, rd_data0;
  logic        full0, afull0, rd_valid0, empty0, aempty0, ovf0, udf0;
  logic [4:0]  count0;

  npu_stream_fifo u0 (
    .CLK(clk), .RST(rst), .flush(flush0), .err_clr(err_clr0),
    .wr_en(wr_en0), .wr_data(wr_data0), .full(full0), .afull(afull0),
    .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .empty(empty0), .aempty(aempty0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  // ---------------- instance 1: FWFT, 26-bit ----------------
  logic        flush1 = 0, err_clr1 = 0, wr_en1 = 0, rd_en1 = 0;
  logic [25:0] wr_data1 = '0, rd_data1;
  logic        full1, afull1, rd_valid1, empty1, aempty1, ovf1, udf1;
  logic [4:0]  count1;

  npu_stream_fifo #(.DATA_W(26), .FWFT(1'b1)) u1 (
    .CLK(clk), .RST(rst), .flush(flush1), .err_clr(err_clr1),
    .wr_en(wr_en1), .wr_data(wr_data1), .full(full1), .afull(afull1),
    .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .empty(empty1), .aempty(aempty1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  // ---------------- instance 2: 4-deep ----------------
  logic        flush2 = 0, err_clr2 = 0, wr_en2 = 0, rd_en2 = 0;
  logic [31:0] wr_data2 = '0, rd_data2;
  logic        full2, afull2, rd_valid2, empty2, aempty2, ovf2, udf2;
  logic [2:0]  count2;

  npu_stream_fifo #(.ADDR_W(2)) u2 (
    .CLK(clk), .RST(rst), .flush(flush2), .err_clr(err_clr2),
    .wr_en(wr_en2), .wr_data(wr_data2), .full(full2), .afull(afull2),
    .rd_en(rd_en2), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .empty(empty2), .aempty(aempty2), .count(count2),
    .overflow(ovf2), .underflow(udf2)
  );

  // ---------------- reference model / scoreboard ----------------
  int          sel = 0;           // which standard-mode instance is exercised (0 or 2)
  logic [31:0] model_q[$];        // words held by the FIFO, oldest first
  logic [31:0] exp_q[$];          // words expected on rd_data, in order
  bit          m_ovf = 0, m_udf = 0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int s);
    return (s == 2) ? 4 : 16;
  endfunction

  // Model status against DUT outputs of the selected instance
  task automatic check_status(input string tag);
    int d, sz;
    logic [31:0] c;
    logic f, af, e, ae, ov, ud;
    d  = depth_of(sel);
    sz = model_q.size();
    if (sel == 2) begin
      c = 32'(count2); f = full2; af = afull2; e = empty2; ae = aempty2; ov = ovf2; ud = udf2;
    end else begin
      c = 32'(count0); f = full0; af = afull0; e = empty0; ae = aempty0; ov = ovf0; ud = udf0;
    end
    chk({tag, " count"},     c,         32'(sz));
    chk({tag, " full"},      32'(f),    32'(sz == d));
    chk({tag, " afull"},     32'(af),   32'(sz >= d - 2));
    chk({tag, " empty"},     32'(e),    32'(sz == 0));
    chk({tag, " aempty"},    32'(ae),   32'(sz <= 2));
    chk({tag, " overflow"},  32'(ov),   32'(m_ovf));
    chk({tag, " underflow"}, 32'(ud),   32'(m_udf));
  endtask

  // Driver: one clock of stimulus on the selected instance, then model update
  task automatic cycle(input bit w, input logic [31:0] d, input bit r,
                       input bit f, input bit ec, input string tag);
    int  dep;
    bit  wa, ra;
    if (sel == 2) begin
      wr_en2 = w; wr_data2 = d; rd_en2 = r; flush2 = f; err_clr2 = ec;
    end else begin
      wr_en0 = w; wr_data0 = d; rd_en0 = r; flush0 = f; err_clr0 = ec;
    end
    @(posedge clk);
    dep = depth_of(sel);
    if (f) begin
      model_q.delete();
      if (ec) begin m_ovf = 0; m_udf = 0; end
    end else begin
      wa = w && (model_q.size() < dep);
      ra = r && (model_q.size() > 0);
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(d);
      m_ovf = (w && !wa) ? 1'b1 : (ec ? 1'b0 : m_ovf);
      m_udf = (r && !ra) ? 1'b1 : (ec ? 1'b0 : m_udf);
    end
    #1;
    check_status(tag);
  endtask

  task automatic idle_all();
    wr_en0 = 0; rd_en0 = 0; flush0 = 0; err_clr0 = 0;
    wr_en1 = 0; rd_en1 = 0; flush1 = 0; err_clr1 = 0;
    wr_en2 = 0; rd_en2 = 0; flush2 = 0; err_clr2 = 0;
  endtask

  // Reset with requests held high: they must be ignored
  task automatic do_reset(input string tag);
    rst = 1;
    wr_en0 = 1; rd_en0 = 1; wr_en1 = 1; rd_en1 = 1; wr_en2 = 1; rd_en2 = 1;
    @(posedge clk);
    model_q.delete();
    exp_q.delete();
    m_ovf = 0; m_udf = 0;
    #1;
    rst = 0;
    idle_all();
    check_status(tag);
    chk({tag, " rd_valid0"}, 32'(rd_valid0), 32'd0);
    chk({tag, " rd_data0"},  rd_data0,       32'd0);
    chk({tag, " rd_valid2"}, 32'(rd_valid2), 32'd0);
    chk({tag, " rd_data2"},  rd_data2,       32'd0);
  endtask

  // Monitor: every rd_valid pulse must carry the next expected word, and
  // every accepted read must have produced its pulse by the following negedge
  always @(negedge clk) begin
    logic        rv;
    logic [31:0] rdat;
    if (!rst && sel != 1) begin
      rv   = (sel == 2) ? rd_valid2 : rd_valid0;
      rdat = (sel == 2) ? rd_data2  : rd_data0;
      if (rv) begin
        if (exp_q.size() == 0) begin
          chk("spurious rd_valid", 32'd1, 32'd0);
        end else begin
          chk("rd_data", rdat, exp_q.pop_front());
        end
      end
      chk("rd_valid latency", 32'(exp_q.size()), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    sel = 0;
    do_reset("reset0");

    // Fill 16 words, then drain in order
    for (int i = 1; i <= 16; i++) cycle(1, 32'(i), 0, 0, 0, "fill");
    for (int i = 0; i < 16; i++) cycle(0, '0, 1, 0, 0, "drain");

    // Full FIFO: read + write together -> read wins, write dropped
    for (int i = 0; i < 16; i++) cycle(1, 32'h100 + 32'(i), 0, 0, 0, "refill");
    cycle(1, 32'hDEADBEEF, 1, 0, 0, "full rw");
    for (int i = 0; i < 15; i++) cycle(0, '0, 1, 0, 0, "drain2");

    // Empty FIFO: read + write together -> underflow, no bypass
    cycle(1, 32'hA5A5A5A5, 1, 0, 0, "empty rw");
    cycle(0, '0, 1, 0, 0, "read a5");
    cycle(0, '0, 0, 0, 1, "err_clr");

    // err_clr with a simultaneous new error keeps the flag set
    cycle(0, '0, 1, 0, 1, "clr vs udf");
    cycle(0, '0, 0, 0, 1, "err_clr2");

    // Five words queued with overflow set, then flush with requests high
    for (int i = 0; i < 16; i++) cycle(1, 32'h200 + 32'(i), 0, 0, 0, "fill3");
    cycle(1, 32'h0BAD0BAD, 0, 0, 0, "ovf");
    for (int i = 0; i < 11; i++) cycle(0, '0, 1, 0, 0, "to5");
    cycle(1, 32'h12345678, 1, 1, 0, "flush");
    cycle(0, '0, 1, 0, 0, "post flush udf");
    cycle(0, '0, 0, 0, 1, "err_clr3");

    // Reset with three words queued
    for (int i = 0; i < 3; i++) cycle(1, 32'h300 + 32'(i), 0, 0, 0, "fill4");
    do_reset("reset3");

    // Random traffic on the default instance
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, "rand0");
    cycle(0, '0, 0, 1, 0, "final flush0");
    idle_all();

    // FWFT, 26-bit instance
    sel = 1;
    do_reset("reset1");
    chk("fwft rst rd_valid", 32'(rd_valid1), 32'd0);
    chk("fwft rst empty",    32'(empty1),    32'd1);
    chk("fwft rst rd_data",  32'(rd_data1),  32'd0);
    wr_en1 = 1; wr_data1 = 26'h3FFFFFF;
    @(posedge clk); #1;
    wr_en1 = 0;
    chk("fwft rd_valid", 32'(rd_valid1), 32'd1);
    chk("fwft rd_data",  32'(rd_data1),  32'h3FFFFFF);
    chk("fwft count",    32'(count1),    32'd1);
    @(posedge clk); #1;
    chk("fwft hold",     32'(rd_data1),  32'h3FFFFFF);
    rd_en1 = 1;
    @(posedge clk); #1;
    rd_en1 = 0;
    chk("fwft pop empty",    32'(empty1),    32'd1);
    chk("fwft pop rd_valid", 32'(rd_valid1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      wr_en1 = 1; wr_data1 = 26'h1000 + 26'(i);
      @(posedge clk); #1;
    end
    wr_en1 = 0;
    for (int i = 0; i < 3; i++) begin
      chk("fwft head", 32'(rd_data1), 32'h1000 + 32'(i));
      rd_en1 = 1;
      @(posedge clk); #1;
      rd_en1 = 0;
    end
    chk("fwft drained", 32'(empty1), 32'd1);
    chk("fwft no udf",  32'(udf1),   32'd0);

    // 4-deep instance: random traffic wraps the pointers many times
    sel = 2;
    do_reset("reset2");
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, "rand2");
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 0, "drain2end");
    idle_all();
    @(posedge clk); #1;

    chk("exp_q drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/npu_stream_fifo.md
Name: npu_stream_fifo

Overview:
Parametrised synchronous FIFO. It is the next generation of the NPU input, config and output queues, and the single queue primitive for processor↔NPU traffic. It generalises the fixed 32-bit queues in data width, depth and read mode (standard or first-word-fall-through). It adds programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.

Parameters:
DATA_W, 32, word width in bits (config queue instantiates 26)
ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AFULL_TH, DEPTH-2, afull asserted when count >= AFULL_TH; legal 1..DEPTH
AEMPTY_TH, 2, aempty asserted when count <= AEMPTY_TH; legal 0..DEPTH-1

Ports:
CLK  in  1  single clock, all state on rising edge
RST  in  1  reset, synchronous, active-high
flush  in  1  synchronous queue clear, keeps error flags
err_clr  in  1  clears overflow/underflow
wr_en  in  1  write request
wr_data  in  DATA_W  write word
full  out  1  count == DEPTH
afull  out  1  count >= AFULL_TH
rd_en  in  1  read/pop request
rd_data  out  DATA_W  read word
rd_valid  out  1  rd_data qualifier
empty  out  1  count == 0
aempty  out  1  count <= AEMPTY_TH
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset values (RST high at an edge): pointers 0, count 0, empty 1, aempty 1, full 0, afull 0, overflow 0, underflow 0, rd_data 0, rd_valid 0. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits. Address = low ADDR_W bits. Wrap is natural modulo 2**(ADDR_W+1).
- count is a register:
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - Unchanged when both or neither are accepted.
- full, afull, empty and aempty are combinational decodes of the registered count. They are never derived from pointer compare.
- Write acceptance: wr_en & ~full, using full as seen in that cycle.
  - A write while full is dropped, memory is unchanged, and overflow is set on the next edge.
  - This holds even if a read is accepted in the same cycle.
- Read acceptance: rd_en & ~empty.
  - A read while empty is rejected and underflow is set.
  - This holds even if a write is accepted in the same cycle; there is no bypass.
- Simultaneous accepted read and write (neither full nor empty): both pointers advance and count holds.
- Standard mode (FWFT=0):
  - On an accepted read, rd_data <= mem[rd_ptr] and rd_valid = 1 on the next cycle. Read latency is 1.
  - rd_valid is a one-cycle pulse per accepted read. rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally.
  - rd_valid = ~empty.
  - rd_en acts as pop/acknowledge.
  - A word written into an empty FIFO appears on rd_data the cycle after its write edge.
- flush:
  - Next edge: pointers 0, count 0, rd_valid 0. Leaves overflow/underflow untouched.
  - wr_en/rd_en in the flush cycle are ignored and raise no error.
- err_clr:
  - Clears both sticky flags on the next edge.
  - A new error event in the same cycle wins: the flag stays/becomes 1.
- Priority: RST > flush > normal operation.
  - RST mid-burst discards all data.
  - A read in flight in standard mode does not produce rd_valid after reset.
- Memory: plain register array, single write port, one read port (registered or combinational per FWFT). No inferred-RAM read-during-write hazards need handling, because a word is never read in its own write cycle.

Decomposition:
- Shared package npu_fifo_pkg:
  - clog2 helper function.
  - Default width/depth constants per NPU queue: NPU_IN_W=32, NPU_CFG_W=26, NPU_OUT_W=32, NPU_FIFO_AW=4.
- One natural sub-module: npu_fifo_mem, the parametrised DATA_W × DEPTH register array with write port and registered/combinational read selected by FWFT.
- Pointer, count and flag logic stays in npu_stream_fifo.

Test Plan:
1. Defaults, FWFT=0. Write 0x00000001..0x00000010 (16 words) → full=1 after 16th edge, afull=1 from count=14, count=16. Then 16 reads → rd_data 0x1..0x10 in order, each with rd_valid one cycle after rd_en; empty=1 at end.
2. Full FIFO. Assert wr_en with data 0xDEADBEEF and rd_en in the same cycle → read returns oldest word, write dropped, overflow=1, count=15. Subsequent drain never returns 0xDEADBEEF.
3. Empty FIFO. Assert rd_en and wr_en(0xA5A5A5A5) together → underflow=1, count=1, rd_valid=0. Next read returns 0xA5A5A5A5.
4. FWFT=1, DATA_W=26. Write 0x3FFFFFF into empty → next cycle rd_valid=1 and rd_data=0x3FFFFFF without rd_en. rd_en pops → empty=1 next cycle.
5. Wrap. ADDR_W=2, 100 random interleaved read/write cycles against a reference queue model → data order and count always match. Pointers wrap past 7 with no corruption.
6. Load 5 words, set overflow, then pulse flush with wr_en=1 → count=0, empty=1, overflow still 1. err_clr → overflow=0. RST with 3 words queued → all reset values restored next edge.
